// File: rtl/row_chunk_mac.sv
// Row-by-vector MAC lane: dot product of one matrix row with the vector, chunk by chunk.
// Four-stage path: products, adder tree, accumulate, result strobe.
module row_chunk_mac #(
    parameter int element_width = 32,
    parameter int no_of_units   = 8,
    parameter int acc_width     = 80,
    parameter int count_width   = 32
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 start,
    input  logic [count_width-1:0]               no_of_multiples,
    input  logic [element_width*no_of_units-1:0] row_chunk,
    input  logic [element_width*no_of_units-1:0] vector_chunk,
    input  logic                                 chunk_valid,
    output logic                                 chunk_ready,
    output logic [acc_width-1:0]                 result,
    output logic                                 result_valid,
    output logic                                 I_am_ready,
    output logic                                 busy
);
    localparam int prod_width = 2 * element_width;
    localparam int sum_width  = prod_width + $clog2(no_of_units);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE0 = 2'd3;

    logic [1:0]                   state_reg;
    logic [count_width-1:0]       n_reg;
    logic [count_width-1:0]       count_reg;
    logic signed [prod_width-1:0] prod_next [no_of_units];
    logic signed [prod_width-1:0] prod_reg  [no_of_units];
    logic signed [sum_width-1:0]  sum_next;
    logic signed [sum_width-1:0]  sum_reg;
    logic signed [acc_width-1:0]  acc_reg;
    logic [acc_width-1:0]         result_reg;
    logic                         result_valid_reg;
    logic                         v1_reg, last1_reg;
    logic                         v2_reg, last2_reg;
    logic                         v3_reg, last3_reg;
    logic                         accept;
    logic                         is_last;

    assign chunk_ready  = (state_reg == ACCUM) && (count_reg < n_reg);
    assign accept       = chunk_valid && chunk_ready;
    assign is_last      = (count_reg + count_width'(1)) == n_reg;
    assign result       = result_reg;
    assign result_valid = result_valid_reg;
    assign I_am_ready   = (state_reg == IDLE);
    assign busy         = (state_reg == ACCUM) || (state_reg == DRAIN);

    // Lane 0 sits at the MSBs of each chunk.
    generate
        for (genvar gi = 0; gi < no_of_units; gi++) begin : g_lane
            logic signed [element_width-1:0] a_lane;
            logic signed [element_width-1:0] x_lane;
            assign a_lane = row_chunk[(no_of_units-gi)*element_width-1 -: element_width];
            assign x_lane = vector_chunk[(no_of_units-gi)*element_width-1 -: element_width];
            assign prod_next[gi] = prod_width'(a_lane) * prod_width'(x_lane);
        end
    endgenerate

    always_comb begin
        sum_next = '0;
        for (int k = 0; k < no_of_units; k++) begin
            sum_next = sum_next + sum_width'(prod_reg[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            n_reg            <= '0;
            count_reg        <= '0;
            for (int k = 0; k < no_of_units; k++) prod_reg[k] <= '0;
            sum_reg          <= '0;
            acc_reg          <= '0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
            v1_reg           <= 1'b0;
            last1_reg        <= 1'b0;
            v2_reg           <= 1'b0;
            last2_reg        <= 1'b0;
            v3_reg           <= 1'b0;
            last3_reg        <= 1'b0;
        end else begin
            result_valid_reg <= 1'b0;

            v1_reg    <= accept;
            last1_reg <= accept && is_last;
            if (accept) begin
                for (int k = 0; k < no_of_units; k++) prod_reg[k] <= prod_next[k];
            end
            v2_reg    <= v1_reg;
            last2_reg <= last1_reg;
            if (v1_reg) sum_reg <= sum_next;
            v3_reg    <= v2_reg;
            last3_reg <= last2_reg;
            if (v2_reg) acc_reg <= acc_reg + acc_width'(sum_reg);
            if (v3_reg && last3_reg) begin
                result_reg       <= acc_reg;
                result_valid_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    // The result-strobe cycle is still closing the previous row.
                    if (start && !result_valid_reg) begin
                        n_reg     <= no_of_multiples;
                        count_reg <= '0;
                        acc_reg   <= '0;
                        if (no_of_multiples == '0) begin
                            state_reg        <= DONE0;
                            result_reg       <= '0;
                            result_valid_reg <= 1'b1;
                        end else begin
                            state_reg <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        count_reg <= count_reg + count_width'(1);
                        if (is_last) state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (v3_reg && last3_reg) state_reg <= IDLE;
                end
                DONE0: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_row_chunk_mac.sv
// Directed bench for row_chunk_mac: driver pushes expected results, a monitor pops on result_valid.
module tb_row_chunk_mac;
    localparam int EW = 32;
    localparam int NU = 8;
    localparam int AW = 80;
    localparam int CW = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [CW-1:0]     no_of_multiples;
    logic [EW*NU-1:0]  row_chunk;
    logic [EW*NU-1:0]  vector_chunk;
    logic              chunk_valid;
    logic              chunk_ready;
    logic [AW-1:0]     result;
    logic              result_valid;
    logic              I_am_ready;
    logic              busy;

    row_chunk_mac #(
        .element_width(EW), .no_of_units(NU), .acc_width(AW), .count_width(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .no_of_multiples(no_of_multiples),
        .row_chunk(row_chunk), .vector_chunk(vector_chunk), .chunk_valid(chunk_valid),
        .chunk_ready(chunk_ready), .result(result), .result_valid(result_valid),
        .I_am_ready(I_am_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] val;
        int            due;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    logic [EW*NU-1:0] row_c[$];
    logic [EW*NU-1:0] vec_c[$];
    int               pat[$];

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
        end
    endtask

    function automatic logic [EW*NU-1:0] lanes(input int first, input int count);
        logic [EW*NU-1:0] c;
        c = '0;
        for (int k = 0; k < count; k++) c[(NU-k)*EW-1 -: EW] = EW'(first + k);
        return c;
    endfunction

    function automatic logic [EW*NU-1:0] splat(input logic [EW-1:0] v);
        logic [EW*NU-1:0] c;
        c = '0;
        for (int k = 0; k < NU; k++) c[(NU-k)*EW-1 -: EW] = v;
        return c;
    endfunction

    // Monitor: every result_valid must match the oldest expected row.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && result_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: actual=%0h required=no strobe (cycle %0d)", result, cyc);
            end else begin
                e = sb.pop_front();
                check("result", result, e.val);
                check("latency_cycle", AW'(cyc), AW'(e.due));
            end
        end
    end

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!(I_am_ready && !result_valid) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: actual=busy required=I_am_ready");
        end
    endtask

    task automatic do_row(input int n, input logic [AW-1:0] exp_val, input bit inject,
                          output int ready_cnt);
        int   guard, idx, p, last_acc;
        exp_t e;
        ready_cnt = 0;
        last_acc  = 0;
        wait_idle();
        @(posedge clk); #1;
        start = 1'b1;
        no_of_multiples = CW'(n);
        @(negedge clk);
        if (n == 0) begin
            e.val = '0;
            e.due = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
        if (n == 0) return;
        idx = 0;
        p = 0;
        guard = 0;
        while (idx < n && guard < 200) begin
            row_chunk    = row_c[idx];
            vector_chunk = vec_c[idx];
            chunk_valid  = (pat.size() == 0) ? 1'b1 : (pat[p % pat.size()] != 0);
            start        = inject && (idx == 1);
            no_of_multiples = inject ? CW'(7) : CW'(n);
            @(negedge clk);
            if (chunk_ready) ready_cnt++;
            if (chunk_ready && chunk_valid) begin
                idx++;
                last_acc = cyc;
            end
            @(posedge clk); #1;
            p++;
            guard++;
        end
        chunk_valid = 1'b0;
        start = 1'b0;
        if (idx < n) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: actual=%0d required=%0d", idx, n);
        end else begin
            e.val = exp_val;
            e.due = last_acc + 4;
            sb.push_back(e);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (chunk_ready) ready_cnt++;
        end
    endtask

    initial begin
        int rc;
        int guard;
        reset_n = 1'b0;
        start = 1'b0;
        no_of_multiples = '0;
        row_chunk = '0;
        vector_chunk = '0;
        chunk_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_result", result, '0);
        check("reset_result_valid", AW'(result_valid), '0);
        check("reset_chunk_ready", AW'(chunk_ready), '0);
        check("reset_I_am_ready", AW'(I_am_ready), AW'(1));
        check("reset_busy", AW'(busy), '0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Basic row: 1+2+...+8
        row_c = '{lanes(1, 8)};
        vec_c = '{splat(32'd1)};
        do_row(1, AW'(36), 1'b0, rc);
        check("t1_ready_cycles", AW'(rc), AW'(1));
        repeat (3) @(negedge clk);
        check("t1_result_hold", result, AW'(36));
        check("t1_strobe_low", AW'(result_valid), '0);

        // Three chunks, final one zero-padded in lanes 4..7
        row_c = '{lanes(1, 8), lanes(9, 8), lanes(17, 4)};
        vec_c = '{splat(32'd2), splat(32'd2), splat(32'd2)};
        do_row(3, AW'(420), 1'b0, rc);
        check("t2_ready_cycles", AW'(rc), AW'(3));

        // Most-negative operands: 32 products of 2^62
        row_c = '{splat(32'h8000_0000), splat(32'h8000_0000), splat(32'h8000_0000), splat(32'h8000_0000)};
        vec_c = row_c;
        do_row(4, AW'(1) << 67, 1'b0, rc);

        // Gapped chunk_valid
        row_c = '{splat(32'd1), splat(32'd1), splat(32'd1), splat(32'd1)};
        vec_c = row_c;
        pat = '{1, 0, 0, 1, 1, 0, 1};
        do_row(4, AW'(32), 1'b0, rc);
        pat.delete();

        // Empty row, then a start pulse during ACCUM that must be ignored
        do_row(0, '0, 1'b0, rc);
        row_c = '{lanes(1, 8), lanes(1, 8)};
        vec_c = '{splat(32'd1), splat(32'd1)};
        do_row(2, AW'(72), 1'b1, rc);
        check("t5_ready_cycles", AW'(rc), AW'(2));

        // Reset after two accepts of a five-chunk row
        wait_idle();
        row_chunk = splat(32'd1);
        vector_chunk = splat(32'd1);
        @(posedge clk); #1;
        start = 1'b1;
        no_of_multiples = CW'(5);
        @(posedge clk); #1;
        start = 1'b0;
        chunk_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chunk_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        check("t6_busy_before_reset", AW'(busy), AW'(1));
        @(negedge clk);
        check("t6_I_am_ready", AW'(I_am_ready), AW'(1));
        check("t6_result_cleared", result, '0);
        check("t6_busy", AW'(busy), '0);
        check("t6_chunk_ready", AW'(chunk_ready), '0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        row_c = '{splat(32'd3)};
        vec_c = '{splat(32'd3)};
        do_row(1, AW'(72), 1'b0, rc);

        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL missing_results: actual=%0d pending required=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
